lsu_axi_master: RTL and testbench



---
 rtl/lsu_axi_pkg.sv | 51 +++++
 rtl/lsu_align.sv | 62 ++++++
 rtl/lsu_axi_master.sv | 202 ++++++++++++++++++++
 tb/tb_lsu_axi_master.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_axi_pkg.sv
// Shared encodings for the load/store unit AXI4-Lite master: FSM states,
// RISC-V store/load type codes, AXI response codes and access-size helpers.
package lsu_axi_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_WRESP   = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_DATA = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    localparam logic [1:0] ST_SB = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SW = 2'b10;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Unused encodings fall back to a full word access.
    function automatic size_t store_size(input logic [1:0] st);
        case (st)
            ST_SB:   return SZ_BYTE;
            ST_SH:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic size_t load_size(input logic [2:0] lt);
        case (lt[1:0])
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Purely combinational lane logic: store strobes and data replication,
// misalignment detect for a new request, and load byte/halfword extraction.
module lsu_align
    import lsu_axi_pkg::*;
(
    input  logic        i_is_store,
    input  logic [1:0]  i_req_addr_lo,
    input  logic [31:0] i_req_wdata,
    input  logic [1:0]  i_store_type,
    input  logic [2:0]  i_load_type,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic        o_misaligned,
    input  logic [1:0]  i_rsp_addr_lo,
    input  logic [2:0]  i_rsp_load_type,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_load_data
);

    size_t       w_req_size;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_req_size = i_is_store ? store_size(i_store_type) : load_size(i_load_type);
        case (w_req_size)
            SZ_HALF: o_misaligned = i_req_addr_lo[0];
            SZ_WORD: o_misaligned = (i_req_addr_lo != 2'b00);
            default: o_misaligned = 1'b0;
        endcase
    end

    always_comb begin
        case (store_size(i_store_type))
            SZ_BYTE: begin
                o_wstrb = 4'b0001 << i_req_addr_lo;
                o_wdata = {4{i_req_wdata[7:0]}};
            end
            SZ_HALF: begin
                o_wstrb = 4'b0011 << i_req_addr_lo;
                o_wdata = {2{i_req_wdata[15:0]}};
            end
            default: begin
                o_wstrb = 4'b1111;
                o_wdata = i_req_wdata;
            end
        endcase
    end

    always_comb begin
        w_byte = i_rdata[{i_rsp_addr_lo, 3'b000} +: 8];
        w_half = i_rsp_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_rsp_load_type)
            LD_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
            LD_LBU:  o_load_data = {24'h0, w_byte};
            LD_LH:   o_load_data = {{16{w_half[15]}}, w_half};
            LD_LHU:  o_load_data = {16'h0, w_half};
            default: o_load_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_axi_master.sv
// Memory-stage load/store unit: turns one pipeline access into a single
// AXI4-Lite read or write transaction and stalls the pipeline until it ends.
//
// state     | meaning
// S_IDLE    | waiting for a memory-stage request
// S_WR      | AW and/or W still outstanding
// S_WRESP   | waiting for the write response
// S_RD_ADDR | AR outstanding
// S_RD_DATA | waiting for read data
// S_DONE    | one-cycle completion pulse
module lsu_axi_master
    import lsu_axi_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  store_type,
    input  logic [2:0]  load_type,
    output logic        stall,
    output logic        done,
    output logic [31:0] read_data,
    output logic        access_err,
    output logic [31:0] awaddr,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output logic [31:0] araddr,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready
);

    state_t      r_state;
    state_t      w_next;
    logic        r_live;
    logic [31:0] r_bus_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [1:0]  r_addr_lo;
    logic [2:0]  r_load_type;
    logic [31:0] r_read_data;
    logic        r_err;
    logic        r_awvalid;
    logic        r_wvalid;
    logic        r_arvalid;
    logic        r_bready;
    logic        r_rready;

    logic        w_req;
    logic        w_err_next;
    logic        w_start;
    logic        w_misaligned;
    logic [3:0]  w_wstrb_fmt;
    logic [31:0] w_wdata_fmt;
    logic [31:0] w_load_data;

    lsu_align u_align (
        .i_is_store      (mem_write),
        .i_req_addr_lo   (addr[1:0]),
        .i_req_wdata     (wdata),
        .i_store_type    (store_type),
        .i_load_type     (load_type),
        .o_wstrb         (w_wstrb_fmt),
        .o_wdata         (w_wdata_fmt),
        .o_misaligned    (w_misaligned),
        .i_rsp_addr_lo   (r_addr_lo),
        .i_rsp_load_type (r_load_type),
        .i_rdata         (rdata),
        .o_load_data     (w_load_data)
    );

    // r_live holds off requests until the first edge after reset release.
    assign w_req   = r_live & req_valid & (mem_write | mem_read);
    assign w_start = (r_state == S_IDLE) && (w_next == S_WR || w_next == S_RD_ADDR);

    always_comb begin
        w_next     = r_state;
        w_err_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_misaligned) begin
                        w_next     = S_DONE;
                        w_err_next = 1'b1;
                    end else if (mem_write) begin
                        w_next = S_WR;
                    end else begin
                        w_next = S_RD_ADDR;
                    end
                end
            end
            S_WR: begin
                if ((!r_awvalid || awready) && (!r_wvalid || wready))
                    w_next = S_WRESP;
            end
            S_WRESP: begin
                if (bvalid) begin
                    w_next     = S_DONE;
                    w_err_next = (bresp != RESP_OKAY);
                end
            end
            S_RD_ADDR: begin
                if (arready)
                    w_next = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (rvalid) begin
                    w_next     = S_DONE;
                    w_err_next = (rresp != RESP_OKAY);
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bus_addr  <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_addr_lo   <= '0;
            r_load_type <= '0;
            r_read_data <= '0;
            r_err       <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_bready    <= 1'b0;
            r_rready    <= 1'b0;
        end else begin
            if (w_start) begin
                r_bus_addr  <= {addr[31:2], 2'b00};
                r_addr_lo   <= addr[1:0];
                r_load_type <= load_type;
                if (mem_write) begin
                    r_wdata <= w_wdata_fmt;
                    r_wstrb <= w_wstrb_fmt;
                end
            end
            // Each write channel valid drops after its own handshake.
            if (r_state == S_IDLE) begin
                r_awvalid <= (w_next == S_WR);
                r_wvalid  <= (w_next == S_WR);
            end else if (r_state == S_WR && w_next == S_WR) begin
                r_awvalid <= r_awvalid & ~awready;
                r_wvalid  <= r_wvalid & ~wready;
            end else begin
                r_awvalid <= 1'b0;
                r_wvalid  <= 1'b0;
            end
            r_arvalid <= (w_next == S_RD_ADDR);
            r_bready  <= (w_next == S_WRESP);
            r_rready  <= (w_next == S_RD_DATA);
            r_err     <= w_err_next;
            if (r_state == S_RD_DATA && rvalid)
                r_read_data <= (rresp == RESP_OKAY) ? w_load_data : 32'h0;
        end
    end

    assign stall      = (r_state == S_IDLE) ? w_req : (r_state != S_DONE);
    assign done       = (r_state == S_DONE);
    assign access_err = r_err;
    assign read_data  = r_read_data;
    assign awaddr     = r_bus_addr;
    assign araddr     = r_bus_addr;
    assign awprot     = 3'b000;
    assign arprot     = 3'b000;
    assign awvalid    = r_awvalid;
    assign wvalid     = r_wvalid;
    assign wdata_o    = r_wdata;
    assign wstrb      = r_wstrb;
    assign arvalid    = r_arvalid;
    assign bready     = r_bready;
    assign rready     = r_rready;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master: the bench plays the AXI4-Lite slave with
// per-channel delays and checks bus fields, stall length and load results.
module tb_lsu_axi_master;
    import lsu_axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, mem_write = 1'b0, mem_read = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [1:0]  store_type = '0;
    logic [2:0]  load_type = '0;
    logic        stall, done, access_err;
    logic [31:0] read_data;
    logic [31:0] awaddr, wdata_o, araddr;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, arvalid, bready, rready;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
    logic [1:0]  bresp = '0, rresp = '0;
    logic [31:0] rdata = '0;

    int n_checks = 0;
    int n_pass   = 0;

    int          n_stall, n_done, n_aw, n_w, n_ar, done_cyc;
    logic [31:0] got_awaddr, got_wdata, got_wstrb, got_araddr, got_rd, got_err;

    lsu_axi_master dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .mem_write(mem_write),
        .mem_read(mem_read), .addr(addr), .wdata(wdata), .store_type(store_type),
        .load_type(load_type), .stall(stall), .done(done), .read_data(read_data),
        .access_err(access_err), .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid),
        .awready(awready), .wdata_o(wdata_o), .wstrb(wstrb), .wvalid(wvalid),
        .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Starts at a negedge, presents one request and answers as the slave.
    task automatic do_access(input logic wr, input logic rd, input logic [31:0] a,
                             input logic [31:0] d, input logic [1:0] st, input logic [2:0] lt,
                             input int aw_d, input int w_d, input int b_d, input int ar_d,
                             input int r_d, input logic [1:0] resp, input logic [31:0] word);
        int aw_wait, w_wait, b_wait, ar_wait, r_wait, post;
        logic aw_hs, w_hs, b_hs, ar_hs, r_hs, seen;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0; post = 0;
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; seen = 0;
        n_stall = 0; n_done = 0; n_aw = 0; n_w = 0; n_ar = 0; done_cyc = -1;
        got_awaddr = 'x; got_wdata = 'x; got_wstrb = 'x; got_araddr = 'x;
        got_rd = 'x; got_err = 'x;
        req_valid = 1; mem_write = wr; mem_read = rd; addr = a; wdata = d;
        store_type = st; load_type = lt;
        for (int cyc = 0; cyc < 60; cyc++) begin
            #1;
            if (stall) n_stall++;
            if (done) begin
                n_done++;
                if (!seen) begin
                    seen = 1; done_cyc = cyc;
                    got_err = 32'(access_err); got_rd = read_data;
                end
            end
            if (b_hs) bvalid = 0;
            else if (aw_hs && w_hs) begin
                if (b_wait >= b_d) begin
                    bvalid = 1; bresp = resp;
                    if (bready) b_hs = 1;
                end else b_wait++;
            end
            if (r_hs) rvalid = 0;
            else if (ar_hs) begin
                if (r_wait >= r_d) begin
                    rvalid = 1; rresp = resp; rdata = word;
                    if (rready) r_hs = 1;
                end else r_wait++;
            end
            awready = 0;
            if (awvalid) begin
                if (aw_hs || aw_wait >= aw_d) begin
                    awready = 1; n_aw++; aw_hs = 1; got_awaddr = awaddr;
                end else aw_wait++;
            end
            wready = 0;
            if (wvalid) begin
                if (w_hs || w_wait >= w_d) begin
                    wready = 1; n_w++; w_hs = 1;
                    got_wdata = wdata_o; got_wstrb = 32'(wstrb);
                end else w_wait++;
            end
            arready = 0;
            if (arvalid) begin
                if (ar_hs || ar_wait >= ar_d) begin
                    arready = 1; n_ar++; ar_hs = 1; got_araddr = araddr;
                end else ar_wait++;
            end
            if (seen) begin
                req_valid = 0; mem_write = 0; mem_read = 0;
                post++;
            end
            if (post >= 4) break;
            @(negedge clk);
        end
        req_valid = 0; mem_write = 0; mem_read = 0;
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        bresp = 0; rresp = 0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with a live request present: everything must stay quiet.
        req_valid = 1; mem_write = 1; addr = 32'h100; store_type = ST_SW;
        @(negedge clk); #1;
        chk("rst_ctrl", 32'({stall, done, access_err, awvalid, wvalid, bready, arvalid, rready}), 32'h0);
        chk("rst_rdata", read_data, 32'h0);
        chk("rst_awaddr", awaddr, 32'h0);
        @(negedge clk);
        req_valid = 0; mem_write = 0; rst = 1;
        @(negedge clk);

        do_access(1, 0, 32'h100, 32'hDEADBEEF, ST_SW, LD_LW, 0, 0, 0, 0, 0, RESP_OKAY, 0);
        chk("sw_wstrb", got_wstrb, 32'hF);
        chk("sw_wdata", got_wdata, 32'hDEADBEEF);
        chk("sw_awaddr", got_awaddr, 32'h100);
        chk("sw_stall_cycles", 32'(n_stall), 32'd3);
        chk("sw_done_cycle", 32'(done_cyc), 32'd3);
        chk("sw_done_count", 32'(n_done), 32'd1);
        chk("sw_err", got_err, 32'h0);
        chk("sw_handshakes", 32'({n_aw[7:0], n_w[7:0], n_ar[7:0]}), 32'h010100);

        do_access(1, 0, 32'h103, 32'h000000A5, ST_SB, LD_LW, 0, 0, 0, 0, 0, RESP_OKAY, 0);
        chk("sb_awaddr", got_awaddr, 32'h100);
        chk("sb_wstrb", got_wstrb, 32'h8);
        chk("sb_wdata", got_wdata, 32'hA5A5A5A5);

        do_access(1, 0, 32'h102, 32'h00001234, ST_SH, LD_LW, 0, 0, 0, 0, 0, RESP_OKAY, 0);
        chk("sh_wstrb", got_wstrb, 32'hC);
        chk("sh_wdata", got_wdata, 32'h12341234);

        do_access(0, 1, 32'h102, 0, ST_SB, LD_LB, 0, 0, 0, 0, 0, RESP_OKAY, 32'h0080FF00);
        chk("lb_araddr", got_araddr, 32'h100);
        chk("lb_data", got_rd, 32'hFFFFFF80);
        chk("lb_err", got_err, 32'h0);

        do_access(0, 1, 32'h102, 0, ST_SB, LD_LBU, 0, 0, 0, 0, 0, RESP_OKAY, 32'h0080FF00);
        chk("lbu_data", got_rd, 32'h00000080);

        do_access(0, 1, 32'h101, 0, ST_SB, LD_LH, 0, 0, 0, 0, 0, RESP_OKAY, 32'h11111111);
        chk("mis_lh_no_ar", 32'(n_ar), 32'd0);
        chk("mis_lh_done_cycle", 32'(done_cyc), 32'd1);
        chk("mis_lh_err", got_err, 32'h1);
        chk("mis_lh_rdata_kept", got_rd, 32'h00000080);

        do_access(0, 1, 32'h102, 0, ST_SB, LD_LH, 0, 0, 0, 0, 0, RESP_OKAY, 32'h80010000);
        chk("lh_data", got_rd, 32'hFFFF8001);
        do_access(0, 1, 32'h102, 0, ST_SB, LD_LHU, 0, 0, 0, 0, 0, RESP_OKAY, 32'h80010000);
        chk("lhu_data", got_rd, 32'h00008001);

        do_access(0, 1, 32'h104, 0, ST_SB, LD_LW, 0, 0, 0, 0, 0, RESP_SLVERR, 32'hAAAA5555);
        chk("lw_slverr_err", got_err, 32'h1);
        chk("lw_slverr_data", got_rd, 32'h0);

        do_access(1, 0, 32'h104, 32'h01020304, ST_SW, LD_LW, 0, 0, 0, 0, 0, RESP_DECERR, 0);
        chk("sw_decerr_err", got_err, 32'h1);

        do_access(1, 1, 32'h108, 32'h55AA55AA, ST_SW, LD_LW, 0, 0, 0, 0, 0, RESP_OKAY, 0);
        chk("both_is_store", 32'({n_aw[7:0], n_ar[7:0]}), 32'h0100);
        chk("both_wdata", got_wdata, 32'h55AA55AA);

        do_access(1, 0, 32'h102, 32'h12345678, ST_SW, LD_LW, 0, 0, 0, 0, 0, RESP_OKAY, 0);
        chk("mis_sw_no_aw", 32'({n_aw[7:0], n_w[7:0]}), 32'h0);
        chk("mis_sw_err", got_err, 32'h1);

        do_access(1, 0, 32'h10C, 32'h0BADF00D, ST_SW, LD_LW, 0, 5, 0, 0, 0, RESP_OKAY, 0);
        chk("sw_wdly_stall_cycles", 32'(n_stall), 32'd8);
        chk("sw_wdly_done_cycle", 32'(done_cyc), 32'd8);
        chk("sw_wdly_done_count", 32'(n_done), 32'd1);
        chk("sw_wdly_handshakes", 32'({n_aw[7:0], n_w[7:0]}), 32'h0101);

        do_access(0, 1, 32'h104, 0, ST_SB, LD_LW, 0, 0, 0, 0, 3, RESP_OKAY, 32'h12345678);
        chk("lw_rdly_stall_cycles", 32'(n_stall), 32'd6);
        chk("lw_rdly_done_count", 32'(n_done), 32'd1);
        chk("lw_rdly_data", got_rd, 32'h12345678);

        // Asynchronous reset while waiting for read data.
        req_valid = 1; mem_read = 1; mem_write = 0; addr = 32'h200; load_type = LD_LW;
        @(negedge clk); #1;
        arready = arvalid;
        @(negedge clk); arready = 0; #1;
        chk("mid_rst_in_rd_data", 32'(rready), 32'h1);
        #2 rst = 0; #1;
        chk("mid_rst_ctrl", 32'({arvalid, rready, stall, done}), 32'h0);
        chk("mid_rst_rdata", read_data, 32'h0);
        @(negedge clk);
        req_valid = 0; mem_read = 0; rst = 1;
        @(negedge clk);

        do_access(1, 0, 32'h300, 32'hCAFEF00D, ST_SW, LD_LW, 0, 0, 0, 0, 0, RESP_OKAY, 0);
        chk("post_rst_sw_done", 32'({n_done[7:0], done_cyc[7:0]}), 32'h0103);
        chk("post_rst_sw_awaddr", got_awaddr, 32'h300);
        chk("post_rst_sw_err", got_err, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
